// File: rtl/pc_sequencer.sv
// Program-counter sequencer: generates fetch addresses and drives the 16-entry
// return-address stack for CALL/RETURN/GOTO/skip/interrupt control flow.
module pc_sequencer #(
  parameter int unsigned   PC_W      = 11,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(0),
  parameter logic [PC_W-1:0] INT_VEC   = PC_W'(4),
  parameter int unsigned   DEPTH     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            op_goto,
  input  logic            op_call,
  input  logic            op_ret,
  input  logic            op_retfie,
  input  logic            op_skip,
  input  logic [PC_W-1:0] target,
  input  logic            irq,
  input  logic [PC_W-1:0] stack_out,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] stack_in,
  output logic            push,
  output logic            pop,
  output logic            flush,
  output logic            gie,
  output logic [4:0]      stk_depth,
  output logic            stk_ovf,
  output logic            stk_unf
);

  localparam int unsigned DEPTH_W = 5;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                gie_q, gie_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                any_op;
  logic                push_int, pop_int;

  assign any_op = op_goto | op_call | op_ret | op_retfie | op_skip;

  // State register; reset overrides any event presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FLUSH;
      pc_q    <= RESET_VEC;
      gie_q   <= 1'b0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      gie_q   <= gie_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Next-state, next-pc and stack strobe selection in strict priority order.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    gie_d    = gie_q;
    push_int = 1'b0;
    pop_int  = 1'b0;
    if (!stall) begin
      case (state_q)
        ST_FLUSH: begin
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_RUN;
        end
        default: begin
          if (irq && gie_q && !any_op) begin
            push_int = 1'b1;
            pc_d     = INT_VEC;
            gie_d    = 1'b0;
            state_d  = ST_FLUSH;
          end else if (op_ret || op_retfie) begin
            pop_int = 1'b1;
            pc_d    = stack_out;
            if (op_retfie) gie_d = 1'b1;
            state_d = ST_FLUSH;
          end else if (op_call) begin
            push_int = 1'b1;
            pc_d     = target;
            state_d  = ST_FLUSH;
          end else if (op_goto) begin
            pc_d    = target;
            state_d = ST_FLUSH;
          end else if (op_skip) begin
            pc_d    = pc_q + PC_W'(1);
            state_d = ST_FLUSH;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      endcase
    end
  end

  // Depth tracking: saturate on push at full, floor on pop at empty, sticky flags.
  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (push_int) begin
      if (depth_q == DEPTH_W'(DEPTH)) ovf_d = 1'b1;
      else                            depth_d = depth_q + DEPTH_W'(1);
    end else if (pop_int) begin
      if (depth_q == '0) unf_d = 1'b1;
      else               depth_d = depth_q - DEPTH_W'(1);
    end
  end

  // Stack strobes are combinational so the stack updates on the same edge as pc.
  assign push      = push_int & ~rst;
  assign pop       = pop_int & ~rst;
  assign stack_in  = pc_q;
  assign pc        = pc_q;
  assign flush     = (state_q == ST_FLUSH);
  assign gie       = gie_q;
  assign stk_depth = depth_q;
  assign stk_ovf   = ovf_q;
  assign stk_unf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, op_goto, op_call, op_ret, op_retfie, op_skip, irq;
  logic [10:0] target, stack_out;
  logic [10:0] pc, stack_in;
  logic        push, pop, flush, gie, stk_ovf, stk_unf;
  logic [4:0]  stk_depth;
  int          checks = 0;
  int          errors = 0;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .op_goto(op_goto), .op_call(op_call),
    .op_ret(op_ret), .op_retfie(op_retfie), .op_skip(op_skip), .target(target),
    .irq(irq), .stack_out(stack_out), .pc(pc), .stack_in(stack_in), .push(push),
    .pop(pop), .flush(flush), .gie(gie), .stk_depth(stk_depth), .stk_ovf(stk_ovf),
    .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ops();
    op_goto = 0; op_call = 0; op_ret = 0; op_retfie = 0; op_skip = 0; irq = 0; stall = 0;
  endtask

  task automatic do_reset();
    clr_ops();
    rst = 1; tick(); rst = 0;
  endtask

  // Jump so that pc==a in a RUN cycle afterwards.
  task automatic goto_run(input logic [10:0] a);
    op_goto = 1; target = a - 11'd1; tick(); op_goto = 0; tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 11'h000) begin errors++; $display("FAIL reset_pc: got %h expected 000", pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL reset_flush: got %b expected 1", flush); end
    checks++; if ({gie, stk_depth, stk_ovf, stk_unf} !== 8'h00) begin errors++; $display("FAIL reset_flags: got gie=%b depth=%0d ovf=%b unf=%b expected all 0", gie, stk_depth, stk_ovf, stk_unf); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc !== 11'(i) || flush !== 1'b0) begin errors++; $display("FAIL freerun_%0d: got pc=%h flush=%b expected pc=%h flush=0", i, pc, flush, 11'(i)); end
    end
  endtask

  task automatic test_wrap();
    op_goto = 1; target = 11'h7FF; tick(); op_goto = 0;
    checks++; if (pc !== 11'h7FF || flush !== 1'b1) begin errors++; $display("FAIL wrap_goto: got pc=%h flush=%b expected 7ff/1", pc, flush); end
    tick();
    checks++; if (pc !== 11'h000 || flush !== 1'b0) begin errors++; $display("FAIL wrap_inc: got pc=%h flush=%b expected 000/0", pc, flush); end
  endtask

  task automatic test_call_ret();
    goto_run(11'h010);
    op_call = 1; target = 11'h120; #1;
    checks++; if (push !== 1'b1 || stack_in !== 11'h010) begin errors++; $display("FAIL call_push: got push=%b stack_in=%h expected 1/010", push, stack_in); end
    tick(); op_call = 0;
    checks++; if (pc !== 11'h120 || flush !== 1'b1 || stk_depth !== 5'd1) begin errors++; $display("FAIL call_pc: got pc=%h flush=%b depth=%0d expected 120/1/1", pc, flush, stk_depth); end
    tick();
    checks++; if (pc !== 11'h121 || flush !== 1'b0) begin errors++; $display("FAIL call_next: got pc=%h flush=%b expected 121/0", pc, flush); end
    op_ret = 1; stack_out = 11'h010; #1;
    checks++; if (pop !== 1'b1 || push !== 1'b0) begin errors++; $display("FAIL ret_pop: got pop=%b push=%b expected 1/0", pop, push); end
    tick(); op_ret = 0;
    checks++; if (pc !== 11'h010 || flush !== 1'b1 || stk_depth !== 5'd0 || stk_unf !== 1'b0) begin errors++; $display("FAIL ret_pc: got pc=%h flush=%b depth=%0d unf=%b expected 010/1/0/0", pc, flush, stk_depth, stk_unf); end
    tick();
    checks++; if (pc !== 11'h011) begin errors++; $display("FAIL ret_next: got pc=%h expected 011", pc); end
  endtask

  task automatic test_ovf_unf();
    do_reset(); tick();
    op_ret = 1; stack_out = 11'h055; #1;
    checks++; if (pop !== 1'b1) begin errors++; $display("FAIL unf_pop: got %b expected 1", pop); end
    tick(); op_ret = 0;
    checks++; if (stk_unf !== 1'b1 || stk_depth !== 5'd0 || pc !== 11'h055) begin errors++; $display("FAIL unf_flag: got unf=%b depth=%0d pc=%h expected 1/0/055", stk_unf, stk_depth, pc); end
    tick();
    for (int i = 0; i < 17; i++) begin
      op_call = 1; target = 11'h200 + 11'(i); #1;
      checks++; if (push !== 1'b1) begin errors++; $display("FAIL ovf_push_%0d: got %b expected 1", i, push); end
      tick(); op_call = 0;
      if (i == 15) begin
        checks++; if (stk_depth !== 5'd16 || stk_ovf !== 1'b0) begin errors++; $display("FAIL full_16: got depth=%0d ovf=%b expected 16/0", stk_depth, stk_ovf); end
      end
      tick();
    end
    checks++; if (stk_depth !== 5'd16 || stk_ovf !== 1'b1) begin errors++; $display("FAIL ovf_17: got depth=%0d ovf=%b expected 16/1", stk_depth, stk_ovf); end
  endtask

  task automatic test_interrupt();
    do_reset(); tick();
    op_retfie = 1; stack_out = 11'h032; tick(); op_retfie = 0;
    checks++; if (gie !== 1'b1 || pc !== 11'h032) begin errors++; $display("FAIL retfie: got gie=%b pc=%h expected 1/032", gie, pc); end
    tick();
    irq = 1; #1;
    checks++; if (push !== 1'b1 || stack_in !== 11'h033) begin errors++; $display("FAIL irq_push: got push=%b stack_in=%h expected 1/033", push, stack_in); end
    tick(); irq = 0;
    checks++; if (pc !== 11'h004 || gie !== 1'b0 || flush !== 1'b1 || stk_depth !== 5'd1) begin errors++; $display("FAIL irq_vec: got pc=%h gie=%b flush=%b depth=%0d expected 004/0/1/1", pc, gie, flush, stk_depth); end
    tick();
    op_retfie = 1; stack_out = 11'h060; tick(); op_retfie = 0; tick();
    irq = 1; op_goto = 1; target = 11'h070; #1;
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL irq_goto_push: got %b expected 0", push); end
    tick(); op_goto = 0;
    checks++; if (pc !== 11'h070 || flush !== 1'b1 || push !== 1'b0) begin errors++; $display("FAIL irq_goto_pc: got pc=%h flush=%b push=%b expected 070/1/0", pc, flush, push); end
    tick();
    checks++; if (pc !== 11'h071 || push !== 1'b1 || stack_in !== 11'h071) begin errors++; $display("FAIL irq_late: got pc=%h push=%b stack_in=%h expected 071/1/071", pc, push, stack_in); end
    tick(); irq = 0;
    checks++; if (pc !== 11'h004 || gie !== 1'b0) begin errors++; $display("FAIL irq_late_vec: got pc=%h gie=%b expected 004/0", pc, gie); end
  endtask

  task automatic test_skip_stall();
    do_reset(); tick();
    goto_run(11'h050);
    op_skip = 1; tick(); op_skip = 0;
    checks++; if (pc !== 11'h051 || flush !== 1'b1) begin errors++; $display("FAIL skip_pc: got pc=%h flush=%b expected 051/1", pc, flush); end
    tick();
    checks++; if (pc !== 11'h052 || flush !== 1'b0) begin errors++; $display("FAIL skip_next: got pc=%h flush=%b expected 052/0", pc, flush); end
    stall = 1; op_call = 1; target = 11'h300;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (push !== 1'b0) begin errors++; $display("FAIL stall_push_%0d: got %b expected 0", i, push); end
      tick();
      checks++; if (pc !== 11'h052 || stk_depth !== 5'd0) begin errors++; $display("FAIL stall_hold_%0d: got pc=%h depth=%0d expected 052/0", i, pc, stk_depth); end
    end
    stall = 0; #1;
    checks++; if (push !== 1'b1 || stack_in !== 11'h052) begin errors++; $display("FAIL stall_release: got push=%b stack_in=%h expected 1/052", push, stack_in); end
    tick(); op_call = 0;
    checks++; if (pc !== 11'h300 || stk_depth !== 5'd1) begin errors++; $display("FAIL stall_call: got pc=%h depth=%0d expected 300/1", pc, stk_depth); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      op_call = 1; target = 11'h400; tick(); op_call = 0; tick();
    end
    checks++; if (stk_depth !== 5'd3) begin errors++; $display("FAIL mid_depth: got %0d expected 3", stk_depth); end
    rst = 1; op_call = 1; target = 11'h500; #1;
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL mid_push: got %b expected 0", push); end
    tick(); rst = 0; op_call = 0;
    checks++; if (pc !== 11'h000 || stk_depth !== 5'd0 || stk_ovf !== 1'b0 || gie !== 1'b0 || flush !== 1'b1) begin errors++; $display("FAIL mid_reset: got pc=%h depth=%0d ovf=%b gie=%b flush=%b expected 000/0/0/0/1", pc, stk_depth, stk_ovf, gie, flush); end
  endtask

  initial begin
    rst = 1; target = '0; stack_out = '0;
    clr_ops();
    test_reset();
    test_wrap();
    test_call_ret();
    test_ovf_unf();
    test_interrupt();
    test_skip_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer for the MCU core. It sits directly upstream of the 16-entry, 11-bit return-address stack. It generates the fetch address each cycle and drives the stack's push/pop/stack_in from decoded CALL/RETURN/GOTO/skip/interrupt events. It consumes the stack's top-of-stack output on returns and flags the executing slot as a bubble after every control-flow change.

Parameters:
PC_W, 11, program-counter and stack-entry width
RESET_VEC, 11'h000, fetch address after reset
INT_VEC, 11'h004, interrupt vector address
DEPTH, 16, stack entries, used for depth and overflow tracking

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold all state; ignore ops and irq this cycle
op_goto  in  1  executing instruction is GOTO
op_call  in  1  executing instruction is CALL
op_ret  in  1  executing instruction is RETURN/RETLW
op_retfie  in  1  executing instruction is RETFIE (return and set gie)
op_skip  in  1  executing instruction's skip condition is true
target  in  PC_W  GOTO/CALL destination
irq  in  1  level interrupt request
stack_out  in  PC_W  top-of-stack from the stack block (combinational)
pc  out  PC_W  current fetch address
stack_in  out  PC_W  return address to push
push  out  1  push strobe to the stack
pop  out  1  pop strobe to the stack
flush  out  1  executing slot is invalid; decoder must treat it as NOP
gie  out  1  global interrupt enable
stk_depth  out  5  entries in use, 0..DEPTH
stk_ovf  out  1  sticky: push issued at depth==DEPTH
stk_unf  out  1  sticky: pop issued at depth==0

Behaviour:
- Reset (rst=1 at an edge, overrides everything): pc=RESET_VEC, state=FLUSH, gie=0, stk_depth=0, stk_ovf=0, stk_unf=0. This is valid mid-operation; any op or irq in the same cycle is dropped.
- push, pop and stack_in are combinational from state and inputs, so the stack updates on the same edge as pc. Outside the cases below, push=0, pop=0 and stack_in=pc.
- FSM states:
  - RUN: flush=0.
  - FLUSH: flush=1. All op_* and irq are ignored. pc<=pc+1. Next state is RUN.
- Stall: when stall=1 in either state, pc, state, depth and flags hold, and push=pop=0.
- In RUN with stall=0, events are taken in strict priority order; only one is taken per cycle:
  1. irq && gie && no op_* asserted: push=1, stack_in=pc, pc<=INT_VEC, gie<=0, next FLUSH.
  2. op_ret or op_retfie: pop=1, pc<=stack_out, next FLUSH. op_retfie also sets gie<=1.
  3. op_call: push=1, stack_in=pc (pc is already the return address), pc<=target, next FLUSH.
  4. op_goto: pc<=target, next FLUSH.
  5. op_skip: pc<=pc+1, next FLUSH. The already-fetched instruction is discarded.
  6. Otherwise: pc<=pc+1, stay in RUN.
- A pending irq during an op cycle or a FLUSH cycle is not lost; it is taken at the first eligible RUN cycle while still asserted.
- Arithmetic: pc+1 is modulo 2^PC_W (2047 -> 0). target and stack_out are used unmodified.
- Depth tracking:
  - push: depth<=depth+1, saturating at DEPTH. If depth was already DEPTH, the push is still issued (the stack wraps and overwrites its oldest entry) and stk_ovf<=1.
  - pop: depth<=depth-1, floor 0. If depth was 0, the pop is still issued, pc<=stack_out, and stk_unf<=1.
  - Push and pop never occur together.
- Latency: a control-flow change presented in cycle N puts the new pc on the bus at N+1, with flush=1 in N+1. The first valid instruction from the new address executes at N+2.

Test Plan:
- Reset then free run: rst high 1 cycle -> pc=000 with flush=1. Over the next cycles pc=001,002,003 with flush=0 from the second cycle on. Force pc=7FF, increment -> pc=000.
- CALL/RETURN: at pc=010 assert op_call, target=120 -> push=1, stack_in=010, then pc=120, flush=1, pc=121, stk_depth=1. Later op_ret with stack_out=010 -> pop=1, pc=010, flush=1, stk_depth=0.
- Overflow/underflow: 17 consecutive CALLs (each separated by its FLUSH) -> stk_depth=16, stk_ovf=1 after the 17th. RETURN from depth 0 after reset -> pop=1, stk_unf=1, stk_depth=0.
- Interrupt: gie=1 via op_retfie, irq=1 at pc=033 -> push=1, stack_in=033, pc=004, gie=0. irq asserted on the same cycle as op_goto -> goto wins and irq is taken on the cycle after the FLUSH.
- Skip and stall: op_skip at pc=050 -> pc=051 with flush=1, then pc=052. Assert stall with op_call -> pc, stk_depth and push remain unchanged until stall drops.
- Reset mid-operation: rst together with op_call at depth 3 -> push=0, pc=000, stk_depth=0, stk_ovf=0, gie=0, flush=1.
